// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes BYTES_PER_CYCLE bytes of the 128-bit state per cycle.
// Optional macro SUB_BYTES_SHIFTROWS_EN drives ShiftRows(st) onto out_data instead of st.
module sub_bytes_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NSLICE = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
        $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [127:0]    st;
    logic [127:0]    st_sub;
    logic [CW-1:0]   cnt;

    // Byte 0 is the MSB, so byte idx starts at bit 8*(15-idx).
    function automatic int unsigned byte_lsb(input int unsigned idx);
        return 8 * (15 - idx);
    endfunction

    // Current slice through BYTES_PER_CYCLE parallel S-box lookups; other bytes pass through.
    always_comb begin
        st_sub = st;
        for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
            st_sub[byte_lsb(32'(cnt) * BYTES_PER_CYCLE + k) +: 8] =
                SBOX[st[byte_lsb(32'(cnt) * BYTES_PER_CYCLE + k) +: 8]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= in_data;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    st <= st_sub;
                    if (cnt == CW'(NSLICE - 1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SUB_BYTES_SHIFTROWS_EN
    // Output row r, column c takes st row r, column (c+r)%4.
    always_comb begin
        out_data = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                out_data[byte_lsb(4 * c + r) +: 8] = st[byte_lsb(4 * ((c + r) % 4) + r) +: 8];
            end
        end
    end
`else
    assign out_data = st;
`endif

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed self-checking bench for sub_bytes_iter: default instance plus a BYTES_PER_CYCLE sweep.
module tb_sub_bytes_iter;

    localparam logic [127:0] ZERO_EXP = 128'h63636363636363636363636363636363;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] SWP_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] JUNK     = 128'hdeadbeefcafef00d0123456789abcdef;
`ifdef SUB_BYTES_SHIFTROWS_EN
    localparam logic [127:0] FIPS_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] SWP_EXP  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
`else
    localparam logic [127:0] FIPS_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SWP_EXP  = 128'h637c777bf26b6fc53001672bfed7ab76;
`endif
    localparam int unsigned SW_BPC [4] = '{1, 2, 8, 16};
    localparam int unsigned SW_LAT [4] = '{17, 9, 3, 2};

    logic         clk, rst, in_valid, out_ready;
    logic [127:0] in_data;
    logic         ir, ov, by;
    logic [127:0] od;
    logic         sw_ir [4];
    logic         sw_ov [4];
    logic         sw_by [4];
    logic [127:0] sw_od [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sub_bytes_iter u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
        .out_valid(ov), .out_ready(out_ready), .out_data(od), .busy(by)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        sub_bytes_iter #(.BYTES_PER_CYCLE(SW_BPC[g])) u_sw (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[g]), .in_data(in_data),
            .out_valid(sw_ov[g]), .out_ready(out_ready), .out_data(sw_od[g]), .busy(sw_by[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Count negedges from the accept cycle until out_valid is seen on the default instance.
    task automatic wait_out(output int lat);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int           lat, t0, t1, n;
    int           sw_lat [4];
    logic         got;
    logic [127:0] od1;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 128'(ir), 128'(1'b1));
        chk("reset_out_valid", 128'(ov), 128'(1'b0));
        chk("reset_busy", 128'(by), 128'(1'b0));
        chk("reset_out_data", od, '0);
        rst = 1'b0;

        // Zero state, then backpressure while holding out_ready low.
        @(negedge clk);
        in_valid = 1'b1; in_data = '0;
        chk("zero_accept_ready", 128'(ir), 128'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("zero_busy", 128'(by), 128'(1'b1));
        chk("zero_in_ready_busy", 128'(ir), 128'(1'b0));
        lat = 1;
        while (!ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("zero_latency", 128'(lat), 128'(5));
        chk("zero_data", od, ZERO_EXP);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data", od, ZERO_EXP);
            chk("bp_in_ready", 128'(ir), 128'(1'b0));
            chk("bp_out_valid", 128'(ov), 128'(1'b1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", 128'(ir), 128'(1'b1));
        chk("bp_release_out_valid", 128'(ov), 128'(1'b0));

        // FIPS-197 round-1 vector.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = FIPS_IN;
        wait_out(lat);
        chk("fips_latency", 128'(lat), 128'(5));
        chk("fips_data", od, FIPS_EXP);

        // BYTES_PER_CYCLE sweep on fresh instances.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_data = SWP_IN;
        for (int g = 0; g < 4; g++) begin
            sw_lat[g] = 0;
            chk("sweep_accept_ready", 128'(sw_ir[g]), 128'(1'b1));
        end
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int g = 0; g < 4; g++) begin
                if (sw_lat[g] == 0 && sw_ov[g]) begin
                    sw_lat[g] = c;
                    chk($sformatf("sweep_data_bpc%0d", SW_BPC[g]), sw_od[g], SWP_EXP);
                end
            end
        end
        for (int g = 0; g < 4; g++)
            chk($sformatf("sweep_latency_bpc%0d", SW_BPC[g]), 128'(sw_lat[g]), 128'(SW_LAT[g]));

        // Reset pulse during BUSY with counter at 2.
        in_valid = 1'b1; in_data = FIPS_IN;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy_before", 128'(by), 128'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 128'(ir), 128'(1'b1));
        chk("midrst_out_valid", 128'(ov), 128'(1'b0));
        chk("midrst_busy", 128'(by), 128'(1'b0));
        chk("midrst_out_data", od, '0);
        in_valid = 1'b1; in_data = '0;
        wait_out(lat);
        chk("midrst_fresh_latency", 128'(lat), 128'(5));
        chk("midrst_fresh_data", od, ZERO_EXP);

        // Back-to-back with in_valid and out_ready high; in_data disturbed while BUSY.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = FIPS_IN;
        chk("b2b_first_ready", 128'(ir), 128'(1'b1));
        t0 = cyc; n = 0; got = 1'b0; od1 = '0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) in_data = JUNK;
            if (ov && !got) begin
                od1 = od; got = 1'b1; in_data = '0;
            end
            if (ir) break;
        end
        t1 = cyc;
        chk("b2b_first_seen", 128'(got), 128'(1'b1));
        chk("b2b_first_data", od1, FIPS_EXP);
        chk("b2b_accept_spacing", 128'(t1 - t0), 128'(6));
        wait_out(lat);
        chk("b2b_second_latency", 128'(lat), 128'(5));
        chk("b2b_second_data", od, ZERO_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
